// File: rtl/fetch_sequencer.sv
// fetch_sequencer: IF-stage PC owner with run/halt/single-step FSM, stall and redirect handling.
// Define FETCH_DEBOUNCE_EN to debounce StepBtn over DEBOUNCE_CYCLES cycles.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Tick,
  input  logic        RunMode,
  input  logic        StepBtn,
  input  logic        Stall,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] PCResult,
  output logic        FetchEn,
  output logic        Halted,
  output logic [1:0]  State
);
  typedef enum logic [1:0] {INIT = 2'b00, RUN = 2'b01, HALT = 2'b10, STEP = 2'b11} state_t;
  state_t st, nxt;
  logic [31:0] pend, tgt, nxt_pc;
  logic pend_v, s1, s2, lvl, lvl_q, step_p, adv;
  assign tgt = RedirectTarget & ~32'd3;
  assign State = st;
  always_comb begin
    adv = (st == RUN || st == STEP) && Tick && !Stall;
    nxt_pc = RedirectValid ? tgt : pend_v ? pend : PCResult + 32'd4;
    nxt = (st == INIT || st == RUN) ? (RunMode ? RUN : HALT) :
          st == HALT ? (RunMode ? RUN : step_p ? STEP : HALT) :
          adv ? (RunMode ? RUN : HALT) : STEP;
  end
`ifdef FETCH_DEBOUNCE_EN
  logic [19:0] cnt;
  logic db;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt <= '0;
      db <= 1'b0;
    end else if (s2 == db) begin
      cnt <= '0;
    end else if (cnt == DEBOUNCE_CYCLES - 20'd1) begin
      db <= s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 20'd1;
    end
  end
  assign lvl = db;
`else
  assign lvl = s2;
`endif
  always_ff @(posedge Clk) begin
    if (Reset) begin
      st <= INIT;
      PCResult <= RESET_PC;
      FetchEn <= 1'b0;
      Halted <= 1'b0;
      pend <= '0;
      pend_v <= 1'b0;
      s1 <= 1'b0;
      s2 <= 1'b0;
      lvl_q <= 1'b0;
      step_p <= 1'b0;
    end else begin
      s1 <= StepBtn;
      s2 <= s1;
      lvl_q <= lvl;
      step_p <= lvl && !lvl_q;
      st <= nxt;
      Halted <= nxt == HALT;
      FetchEn <= adv;
      if (adv) begin
        PCResult <= nxt_pc;
        pend_v <= 1'b0;
      end else if (RedirectValid) begin
        pend <= tgt;
        pend_v <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of run, stall, redirect, step, wrap and reset behaviour.
module tb_fetch_sequencer;
  logic clk = 0, rst = 1, rst2 = 1, tick = 0, run_mode = 1, step_btn = 0, stall = 0, rv = 0;
  logic [31:0] rt = 0, ep = 0;
  logic [31:0] pc, pc2;
  logic fe, fe2, hl, hl2;
  logic [1:0] st, st2;
  int checks = 0, failures = 0;
`ifdef FETCH_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif
  always #5 clk = ~clk;
  fetch_sequencer #(.RESET_PC(32'h0), .DEBOUNCE_CYCLES(20'd4)) dut (
    .Clk(clk), .Reset(rst), .Tick(tick), .RunMode(run_mode), .StepBtn(step_btn),
    .Stall(stall), .RedirectValid(rv), .RedirectTarget(rt),
    .PCResult(pc), .FetchEn(fe), .Halted(hl), .State(st));
  fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8), .DEBOUNCE_CYCLES(20'd4)) dut2 (
    .Clk(clk), .Reset(rst2), .Tick(tick), .RunMode(run_mode), .StepBtn(step_btn),
    .Stall(stall), .RedirectValid(rv), .RedirectTarget(rt),
    .PCResult(pc2), .FetchEn(fe2), .Halted(hl2), .State(st2));
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick_once;
    tick = 1;
    cyc(1);
    tick = 0;
  endtask
  initial begin
    cyc(1);
    chk("rst_pc", pc, 32'h0);
    chk("rst_state", st, 2'b00);
    chk("rst_fetchen", fe, 0);
    chk("rst_halted", hl, 0);
    rst = 0;
    cyc(1);
    chk("init_to_run", st, 2'b01);
    chk("run_not_halted", hl, 0);
    tick_once;
    chk("run_pc4", pc, 32'h4);
    chk("run_fe", fe, 1);
    cyc(1);
    chk("fe_drop", fe, 0);
    cyc(2);
    tick_once;
    chk("run_pc8", pc, 32'h8);
    cyc(3);
    tick_once;
    chk("run_pc12", pc, 32'hC);
    cyc(3);
    stall = 1;
    tick_once;
    stall = 0;
    chk("stall_pc", pc, 32'hC);
    chk("stall_fe", fe, 0);
    cyc(3);
    tick_once;
    chk("no_catchup", pc, 32'h10);
    cyc(1);
    rv = 1; rt = 32'h103;
    cyc(1);
    rv = 0;
    chk("redir_hold", pc, 32'h10);
    cyc(1);
    tick_once;
    chk("redir_pend", pc, 32'h100);
    cyc(3);
    tick_once;
    chk("redir_after", pc, 32'h104);
    cyc(3);
    rv = 1; rt = 32'h200;
    tick_once;
    rv = 0;
    chk("redir_live", pc, 32'h200);
    cyc(3);
    tick_once;
    chk("live_no_pend", pc, 32'h204);
    cyc(1);
    stall = 1; rv = 1; rt = 32'h300;
    tick_once;
    stall = 0; rt = 32'h401;
    cyc(1);
    rv = 0;
    chk("stall_redir_hold", pc, 32'h204);
    cyc(1);
    tick_once;
    chk("redir_overwrite", pc, 32'h400);
    cyc(3);
    tick_once;
    chk("overwrite_after", pc, 32'h404);
    run_mode = 0;
    cyc(1);
    chk("halt_state", st, 2'b10);
    chk("halt_flag", hl, 1);
    tick_once;
    chk("halt_no_adv", pc, 32'h404);
    chk("halt_fe", fe, 0);
    step_btn = 1;
    cyc(LAT);
    chk("step_latency_halt", st, 2'b10);
    cyc(1);
    chk("step_state", st, 2'b11);
    chk("step_not_halted", hl, 0);
    cyc(10 - LAT - 1);
    step_btn = 0;
    chk("step_wait_pc", pc, 32'h404);
    cyc(6);
    tick_once;
    chk("step_adv", pc, 32'h408);
    chk("step_fe", fe, 1);
    chk("step_back_halt", st, 2'b10);
    cyc(3);
    tick_once;
    chk("one_step_only", pc, 32'h408);
    ep = 32'h408;
`ifdef FETCH_DEBOUNCE_EN
    repeat (4) begin
      step_btn = 1; cyc(2);
      step_btn = 0; cyc(2);
    end
    cyc(8);
    chk("bounce_no_step", st, 2'b10);
    step_btn = 1;
    cyc(10);
    step_btn = 0;
    chk("stable_step", st, 2'b11);
    cyc(6);
    tick_once;
    chk("stable_step_pc", pc, 32'h40C);
    chk("stable_step_halt", st, 2'b10);
    ep = 32'h40C;
`endif
    step_btn = 1;
    cyc(10);
    step_btn = 0;
    chk("step2_state", st, 2'b11);
    run_mode = 1;
    cyc(2);
    chk("step_run_pending", st, 2'b11);
    tick_once;
    chk("step_run_pc", pc, ep + 32'd4);
    chk("step_to_run", st, 2'b01);
    cyc(6);
    rst2 = 0;
    cyc(1);
    chk("wrap_run", st2, 2'b01);
    chk("wrap_rst_pc", pc2, 32'hFFFF_FFF8);
    tick_once;
    chk("wrap_fffc", pc2, 32'hFFFF_FFFC);
    cyc(3);
    tick_once;
    chk("wrap_zero", pc2, 32'h0);
    run_mode = 0;
    cyc(1);
    chk("wrap_halt", st2, 2'b10);
    step_btn = 1;
    cyc(LAT + 1);
    chk("wrap_step", st2, 2'b11);
    step_btn = 0;
    rv = 1; rt = 32'h500;
    cyc(1);
    rv = 0;
    chk("wrap_pend_hold", pc2, 32'h0);
    rst2 = 1; run_mode = 1; tick = 1;
    cyc(1);
    tick = 0;
    chk("midstep_rst_pc", pc2, 32'hFFFF_FFF8);
    chk("midstep_rst_state", st2, 2'b00);
    chk("midstep_rst_fe", fe2, 0);
    chk("midstep_rst_halted", hl2, 0);
    rst2 = 0;
    cyc(1);
    chk("post_rst_run", st2, 2'b01);
    tick_once;
    chk("no_stale_redirect", pc2, 32'hFFFF_FFFC);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controller that owns the program counter for the IF stage and decides when the instruction fetch advances. Replaces free-running PC stepping on the divided clock with a single-clock sequencer. The sequencer is driven by a `Tick` enable from the clock divider and supports continuous run, halt, and push-button single-step, plus stall and branch/jump redirect. Sits between the clock divider and the instruction memory. `PCResult` also feeds the 8-digit display.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `DEBOUNCE_CYCLES`, 20'd500000: consecutive stable `Clk` cycles required to accept a step-button level change.

Ports:
- `Clk`, input, 1: system clock; the only clock.
- `Reset`, input, 1: synchronous, active-high; clears all state.
- `Tick`, input, 1: one-`Clk`-wide enable pulse from the divider.
- `RunMode`, input, 1: board switch; 1 = run continuously, 0 = halt / single-step.
- `StepBtn`, input, 1: raw, asynchronous push-button.
- `Stall`, input, 1: hazard hold; blocks any PC advance in the current cycle.
- `RedirectValid`, input, 1: branch/jump taken.
- `RedirectTarget`, input, 32: redirect address.
- `PCResult`, output, 32: current fetch address (registered).
- `FetchEn`, output, 1: high for one cycle whenever `PCResult` has just changed value source (advance).
- `Halted`, output, 1: high in HALT state.
- `State`, output, 2: FSM state code, for debug LEDs.

## Operation

- FSM states and codes:
  - INIT = 2'b00: entered on reset, held exactly 1 cycle. Exits to RUN if `RunMode`=1, otherwise to HALT.
  - RUN = 2'b01: advance on every cycle with `Tick & ~Stall`. Goes to HALT the cycle after `RunMode`=0 is sampled.
  - HALT = 2'b10: no advance. A step pulse moves it to STEP. `RunMode`=1 moves it to RUN; if both occur in the same cycle, RUN wins and the step pulse is dropped.
  - STEP = 2'b11: waits for `Tick & ~Stall`, performs exactly one advance, then returns to HALT. `RunMode`=1 here goes to RUN after the pending advance completes.
- Advance:
  - Next PC = redirect target if a redirect is pending or `RedirectValid`=1 this cycle; otherwise `PCResult + 4`.
  - PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
  - `RedirectTarget[1:0]` is forced to 2'b00.
- Redirect without advance (no `Tick`, `Stall`=1, or HALT):
  - Target is latched into a pending register and applied on the next advance.
  - A newer redirect overwrites the pending one.
  - Pending is cleared on the advance that consumes it.
  - `RedirectValid` in the same cycle as an advance uses the live target and does not set pending.
- `Stall` during RUN drops the `Tick`; ticks are not accumulated.
- Step pulse source: `StepBtn` passes through a 2-flop synchronizer, then a rising-edge detector. The result is one pulse per press. Presses outside HALT are ignored.

## Timing

- Reset values:
  - `PCResult` = `RESET_PC`
  - `FetchEn` = 0
  - `Halted` = 0
  - `State` = INIT
  - pending redirect cleared; debounce counter and synchronizer cleared to 0
- Advance decided at edge N; new `PCResult` and `FetchEn`=1 are visible after edge N. `FetchEn` returns to 0 after edge N+1 unless another advance occurs.
- `Halted` and `State` are registered and follow state transitions with 1-cycle latency.
- Reset asserted mid-STEP or with a redirect pending aborts the operation. Nothing from before reset is applied after it.
- Reset has priority over every other input in the same cycle.

## Configuration

- `FETCH_DEBOUNCE_EN` defined:
  - Synchronized `StepBtn` must hold a new level for `DEBOUNCE_CYCLES` consecutive cycles before the debounced level changes.
  - The step pulse fires on the debounced rising edge.
  - Bounces shorter than `DEBOUNCE_CYCLES` produce no step.
- Not defined:
  - No counter.
  - Step pulse fires 3 cycles after the raw rising edge (2 sync + edge detect).
  - `DEBOUNCE_CYCLES` is unused.

## Test plan

- Reset with `RunMode`=1 and `Tick` every 4 cycles -> `State` goes INIT then RUN. `PCResult` steps 0, 4, 8, 12, with `FetchEn` pulsing once per tick.
- RUN with `Stall`=1 on the 2nd tick -> PC sequence 0, 4, 8 (the stalled tick is skipped, no catch-up).
- `RedirectValid`=1, target 32'h0000_0103, asserted between ticks at PC=8 -> next advance PC = 32'h100, and the following advance gives 32'h104.
- `RunMode`=0, then one clean 10-cycle `StepBtn` press (macro on, `DEBOUNCE_CYCLES`=4) -> `State` goes HALT, STEP, HALT. Exactly one advance on the next tick; PC 12 -> 16.
- Macro on: `StepBtn` bouncing with 2-cycle glitches -> no step. Then a stable press -> exactly one step.
- `RESET_PC`=32'hFFFF_FFF8 in RUN -> PC goes FFFF_FFFC, 0000_0000. Then `Reset` asserted mid-STEP with a redirect pending -> PC = FFFF_FFF8, `State`=INIT, and the pending target is never applied.
